// File: rtl/video_timing_gen_if.sv
// ---------------------------------------------------------------------------
// video_timing_gen_if
//   Bundles the pixel-advance enable and all raster outputs of
//   video_timing_gen so they travel as one port.
//
//   Signals:
//     pix_en        pixel-advance enable (into the generator)
//     x, y          current raster position (10 bits each)
//     hsync, vsync  sync outputs, asserted level set by the generator
//     active        high inside the visible area
//     line_start    one-clock pulse when x becomes 0
//     frame_start   one-clock pulse when (x,y) becomes (0,0)
//     vblank_start  one-clock pulse when (x,y) becomes (0,V_ACTIVE)
//     frame_cnt     16-bit frame counter, only with VIDEO_TIMING_FRAME_CNT_EN
//
//   Modports:
//     master  the timing generator (drives raster outputs, reads pix_en)
//     slave   a consumer (drives pix_en, reads raster outputs)
// ---------------------------------------------------------------------------
interface video_timing_gen_if;
    logic        pix_en;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic        line_start;
    logic        frame_start;
    logic        vblank_start;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    modport master (
        input  pix_en,
        output x,
        output y,
        output hsync,
        output vsync,
        output active,
        output line_start,
        output frame_start,
        output vblank_start
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        ,
        output frame_cnt
`endif
    );

    modport slave (
        output pix_en,
        input  x,
        input  y,
        input  hsync,
        input  vsync,
        input  active,
        input  line_start,
        input  frame_start,
        input  vblank_start
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        ,
        input  frame_cnt
`endif
    );
endinterface

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//   Raster timing generator. A horizontal counter steps once per enabled
//   pixel clock and wraps at H_TOTAL-1; the vertical counter steps on each
//   horizontal wrap and wraps at V_TOTAL-1. Every output is a register that
//   is loaded from the *next* counter value, so x, y, syncs, active and the
//   strobes all describe the same pixel in the same cycle.
//
//   Ports:
//     clk    single clock, rising edge
//     reset  asynchronous active-low reset
//     vid    video_timing_gen_if.master (pix_en in, raster outputs out)
//
//   Parameters: H_ACTIVE/H_FP/H_SYNC/H_BP, V_ACTIVE/V_FP/V_SYNC/V_BP,
//   SYNC_POL (asserted level of hsync/vsync). Totals must not exceed 1024
//   and every porch/sync width must be at least 1.
//
//   Optional feature: define VIDEO_TIMING_FRAME_CNT_EN to add the 16-bit
//   vid.frame_cnt output, which increments in the cycle frame_start pulses.
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    video_timing_gen_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Half-open window test: lo <= pos < hi.
    function automatic logic in_window(
        input logic [9:0] pos,
        input logic [9:0] lo,
        input logic [9:0] hi
    );
        return (pos >= lo) && (pos < hi);
    endfunction

    // Sync level for a given "inside sync window" decision.
    function automatic logic sync_level(input logic asserted);
        return asserted ? SYNC_POL : ~SYNC_POL;
    endfunction

    logic [9:0] h_cnt_r;
    logic [9:0] v_cnt_r;
    logic [9:0] x_r;
    logic [9:0] y_r;
    logic       hsync_r;
    logic       vsync_r;
    logic       active_r;
    logic       line_start_r;
    logic       frame_start_r;
    logic       vblank_start_r;

    logic [9:0] h_nxt_s;
    logic [9:0] v_nxt_s;
    logic       hsync_nxt_s;
    logic       vsync_nxt_s;
    logic       active_nxt_s;
    logic       line_nxt_s;
    logic       frame_nxt_s;
    logic       vblank_nxt_s;

    // Next raster position: h wraps every line, v steps only on an h wrap.
    always_comb begin
        h_nxt_s = h_cnt_r;
        v_nxt_s = v_cnt_r;
        if (h_cnt_r == H_LAST) begin
            h_nxt_s = 10'd0;
            if (v_cnt_r == V_LAST) begin
                v_nxt_s = 10'd0;
            end else begin
                v_nxt_s = v_cnt_r + 10'd1;
            end
        end else begin
            h_nxt_s = h_cnt_r + 10'd1;
            v_nxt_s = v_cnt_r;
        end
    end

    // Decode the next position so the output registers load consistent values.
    always_comb begin
        hsync_nxt_s  = sync_level(in_window(h_nxt_s, HS_BEGIN, HS_END));
        vsync_nxt_s  = sync_level(in_window(v_nxt_s, VS_BEGIN, VS_END));
        active_nxt_s = (h_nxt_s < H_VIS) && (v_nxt_s < V_VIS);
        line_nxt_s   = (h_nxt_s == 10'd0);
        frame_nxt_s  = line_nxt_s && (v_nxt_s == 10'd0);
        vblank_nxt_s = line_nxt_s && (v_nxt_s == V_VIS);
    end

    // Counters and output registers; reset parks the counters on the last
    // pixel so the first enabled edge lands on (0,0) with frame_start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_r        <= H_LAST;
            v_cnt_r        <= V_LAST;
            x_r            <= 10'd0;
            y_r            <= 10'd0;
            hsync_r        <= ~SYNC_POL;
            vsync_r        <= ~SYNC_POL;
            active_r       <= 1'b0;
            line_start_r   <= 1'b0;
            frame_start_r  <= 1'b0;
            vblank_start_r <= 1'b0;
        end else if (vid.pix_en) begin
            h_cnt_r        <= h_nxt_s;
            v_cnt_r        <= v_nxt_s;
            x_r            <= h_nxt_s;
            y_r            <= v_nxt_s;
            hsync_r        <= hsync_nxt_s;
            vsync_r        <= vsync_nxt_s;
            active_r       <= active_nxt_s;
            line_start_r   <= line_nxt_s;
            frame_start_r  <= frame_nxt_s;
            vblank_start_r <= vblank_nxt_s;
        end else begin
            // Position and levels hold; strobes last only for the update cycle.
            line_start_r   <= 1'b0;
            frame_start_r  <= 1'b0;
            vblank_start_r <= 1'b0;
        end
    end

    assign vid.x            = x_r;
    assign vid.y            = y_r;
    assign vid.hsync        = hsync_r;
    assign vid.vsync        = vsync_r;
    assign vid.active       = active_r;
    assign vid.line_start   = line_start_r;
    assign vid.frame_start  = frame_start_r;
    assign vid.vblank_start = vblank_start_r;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Frame counter steps on the same edge that raises frame_start, so the
    // first frame after reset already reads 1; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_r <= 16'd0;
        end else if (vid.pix_en && frame_nxt_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign vid.frame_cnt = frame_cnt_r;
`else
    // No frame counter in this build; frame_nxt_s only feeds frame_start.
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//   Two generators share one clock: dut0 with default VGA timing and dut1
//   with a tiny 8x5 raster (positive sync) so whole frames fit in a short
//   run. Stimulus pushes the expected output set for every clock into a
//   per-DUT queue; independent monitors pop and compare after each edge.
//   Hand-computed raster figures are checked at the end.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

    // dut1 geometry: H 4+1+2+1 = 8, V 2+1+1+1 = 5, frame = 40 clocks
    localparam int S_HA = 4, S_HFP = 1, S_HS = 2, S_HBP = 1;
    localparam int S_VA = 2, S_VFP = 1, S_VS = 1, S_VBP = 1;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       act;
        logic       ls;
        logic       fs;
        logic       vbs;
    } sig_t;

    typedef struct {
        sig_t        s;
        logic [15:0] fc;
    } exp_t;

    logic clk;
    logic rst0;
    logic rst1;
    int   n_checks;
    int   n_fail;
    logic stats_on;

    exp_t q0[$];
    exp_t q1[$];

    int          mh[2];
    int          mv[2];
    sig_t        mo[2];
    logic [15:0] mfc[2];

    video_timing_gen_if vif0 ();
    video_timing_gen_if vif1 ();

    video_timing_gen u_dut0 (
        .clk   (clk),
        .reset (rst0),
        .vid   (vif0)
    );

    video_timing_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
        .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
        .SYNC_POL (1'b1)
    ) u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .vid   (vif1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int htot(input int d);
        return (d == 0) ? 800 : (S_HA + S_HFP + S_HS + S_HBP);
    endfunction

    function automatic int vtot(input int d);
        return (d == 0) ? 525 : (S_VA + S_VFP + S_VS + S_VBP);
    endfunction

    function automatic sig_t reset_sig(input int d);
        sig_t s;
        logic pol;
        pol   = (d == 0) ? 1'b0 : 1'b1;
        s.x   = 10'd0;
        s.y   = 10'd0;
        s.hs  = ~pol;
        s.vs  = ~pol;
        s.act = 1'b0;
        s.ls  = 1'b0;
        s.fs  = 1'b0;
        s.vbs = 1'b0;
        return s;
    endfunction

    // Expected outputs for a freshly reached position (update cycle).
    function automatic sig_t decode(input int d, input int h, input int v);
        sig_t s;
        int   ha, hfp, hsw, va, vfp, vsw;
        logic pol;
        if (d == 0) begin
            ha = 640; hfp = 16; hsw = 96; va = 480; vfp = 10; vsw = 2; pol = 1'b0;
        end else begin
            ha = S_HA; hfp = S_HFP; hsw = S_HS; va = S_VA; vfp = S_VFP; vsw = S_VS; pol = 1'b1;
        end
        s.x   = 10'(h);
        s.y   = 10'(v);
        s.hs  = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : ~pol;
        s.vs  = (v >= va + vfp && v < va + vfp + vsw) ? pol : ~pol;
        s.act = (h < ha) && (v < va);
        s.ls  = (h == 0);
        s.fs  = (h == 0) && (v == 0);
        s.vbs = (h == 0) && (v == va);
        return s;
    endfunction

    task automatic model_adv(input int d, input logic rst_low, input logic pe);
        exp_t e;
        if (rst_low) begin
            mh[d]  = htot(d) - 1;
            mv[d]  = vtot(d) - 1;
            mo[d]  = reset_sig(d);
            mfc[d] = 16'd0;
        end else if (pe) begin
            mh[d] = (mh[d] == htot(d) - 1) ? 0 : mh[d] + 1;
            if (mh[d] == 0) begin
                mv[d] = (mv[d] == vtot(d) - 1) ? 0 : mv[d] + 1;
            end
            mo[d] = decode(d, mh[d], mv[d]);
            if (mo[d].fs) begin
                mfc[d] = mfc[d] + 16'd1;
            end
        end else begin
            mo[d].ls  = 1'b0;
            mo[d].fs  = 1'b0;
            mo[d].vbs = 1'b0;
        end
        e.s  = mo[d];
        e.fc = mfc[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Called at posedge+2: sets inputs for the coming edge and queues expectations.
    task automatic step(input logic pe0, input logic pe1);
        vif0.pix_en = pe0;
        vif1.pix_en = pe1;
        model_adv(0, !rst0, pe0);
        model_adv(1, !rst1, pe1);
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic report(input string name, input sig_t a, input sig_t e);
        $display("FAIL %s: got x=%0d y=%0d hs,vs,act,ls,fs,vbs=%b%b%b%b%b%b expected x=%0d y=%0d hs,vs,act,ls,fs,vbs=%b%b%b%b%b%b",
                 name, a.x, a.y, a.hs, a.vs, a.act, a.ls, a.fs, a.vbs,
                 e.x, e.y, e.hs, e.vs, e.act, e.ls, e.fs, e.vbs);
    endtask

    // Monitor for dut0.
    initial begin
        exp_t e;
        sig_t a;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                a = {vif0.x, vif0.y, vif0.hsync, vif0.vsync, vif0.active,
                     vif0.line_start, vif0.frame_start, vif0.vblank_start};
                n_checks++;
                if (a !== e.s) begin
                    n_fail++;
                    report("dut0_outputs", a, e.s);
                end
`ifdef VIDEO_TIMING_FRAME_CNT_EN
                check("dut0_frame_cnt", int'(vif0.frame_cnt), int'(e.fc));
`endif
            end
        end
    end

    // Monitor for dut1.
    initial begin
        exp_t e;
        sig_t a;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a = {vif1.x, vif1.y, vif1.hsync, vif1.vsync, vif1.active,
                     vif1.line_start, vif1.frame_start, vif1.vblank_start};
                n_checks++;
                if (a !== e.s) begin
                    n_fail++;
                    report("dut1_outputs", a, e.s);
                end
`ifdef VIDEO_TIMING_FRAME_CNT_EN
                check("dut1_frame_cnt", int'(vif1.frame_cnt), int'(e.fc));
`endif
            end
        end
    end

    // Raster statistics gathered during the continuous pix_en=1 run.
    int cyc      = 0;
    int hs_cnt   = 0;
    int hs_first = -1;
    int hs_last  = -1;
    int a639     = -1;
    int a640     = -1;
    int ls_last  = -1;
    int ls_per   = -1;
    int fs_last  = -1;
    int fs_per   = -1;
    int vs_acc   = 0;
    int vs_frame = -1;
    int vbs_off  = -1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stats_on) begin
                if (vif0.y == 10'd0 && vif0.hsync == 1'b0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(vif0.x);
                    hs_last = int'(vif0.x);
                end
                if (vif0.y == 10'd0 && vif0.x == 10'd639) a639 = int'(vif0.active);
                if (vif0.y == 10'd0 && vif0.x == 10'd640) a640 = int'(vif0.active);
                if (vif0.line_start) begin
                    if (ls_last >= 0) ls_per = cyc - ls_last;
                    ls_last = cyc;
                end
                if (vif1.frame_start) begin
                    if (fs_last >= 0) begin
                        fs_per   = cyc - fs_last;
                        vs_frame = vs_acc;
                    end
                    fs_last = cyc;
                    vs_acc  = 0;
                end
                if (vif1.vsync == 1'b1) vs_acc++;
                if (vif1.vblank_start && fs_last >= 0) vbs_off = cyc - fs_last;
                cyc++;
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        stats_on    = 1'b0;
        rst0        = 1'b0;
        rst1        = 1'b0;
        vif0.pix_en = 1'b0;
        vif1.pix_en = 1'b0;
        @(posedge clk);
        #2;

        // Reset values while reset is held.
        check("rst_x0",      int'(vif0.x),      0);
        check("rst_y0",      int'(vif0.y),      0);
        check("rst_active0", int'(vif0.active), 0);
        check("rst_hsync0",  int'(vif0.hsync),  1);
        check("rst_vsync1",  int'(vif1.vsync),  0);
        check("rst_fs1",     int'(vif1.frame_start), 0);

        repeat (3) step(1'b1, 1'b1);
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (2) step(1'b0, 1'b0);

        // Continuous run: two default lines plus many small frames.
        stats_on = 1'b1;
        repeat (1700) step(1'b1, 1'b1);
        stats_on = 1'b0;

        // Enable pattern 1,0,0,1: strobes must not stretch across idle cycles.
        repeat (20) begin
            step(1'b1, 1'b1);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            step(1'b1, 1'b1);
        end

        // Mid-line asynchronous reset on dut0 at x=300.
        for (int i = 0; i < 900 && mh[0] != 300; i++) step(1'b1, 1'b1);
        rst0 = 1'b0;
        #1;
        check("async_rst_x0",     int'(vif0.x),      0);
        check("async_rst_y0",     int'(vif0.y),      0);
        check("async_rst_act0",   int'(vif0.active), 0);
        check("async_rst_hsync0", int'(vif0.hsync),  1);
        check("async_rst_vsync0", int'(vif0.vsync),  1);
        check("async_rst_ls0",    int'(vif0.line_start), 0);
        repeat (2) step(1'b1, 1'b1);
        rst0 = 1'b1;
        repeat (60) step(1'b1, 1'b1);

        // Mid-frame reset on dut1 with enable idle after release.
        rst1 = 1'b0;
        repeat (2) step(1'b1, 1'b1);
        rst1 = 1'b1;
        step(1'b0, 1'b0);
        repeat (50) step(1'b1, 1'b1);

        vif0.pix_en = 1'b0;
        vif1.pix_en = 1'b0;
        @(posedge clk);
        #3;
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        // Hand-computed raster figures.
        check("hsync_low_cycles",  hs_cnt,   96);
        check("hsync_first_x",     hs_first, 656);
        check("hsync_last_x",      hs_last,  751);
        check("active_at_x639",    a639,     1);
        check("active_at_x640",    a640,     0);
        check("line_period",       ls_per,   800);
        check("small_frame_period", fs_per,  40);
        check("small_vsync_cycles", vs_frame, 8);
        check("small_vblank_offset", vbs_off, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
